// File: rtl/tf_pkg.sv
// tf_pkg: shared constants, FSM state encoding and float sign helper for the twiddle provider
package tf_pkg;
    localparam int FLOAT_LEN = 32;
    localparam int LOG2N = 13;
    localparam int N = 1 << LOG2N;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    function automatic logic [FLOAT_LEN-1:0] sign_flip(input logic [FLOAT_LEN-1:0] x);
        return {~x[FLOAT_LEN-1], x[FLOAT_LEN-2:0]};
    endfunction
endpackage

// File: rtl/tf_provider_stream_if.sv
// tf_provider_stream_if: control and ready/valid twiddle stream bundle
interface tf_provider_stream_if #(
    parameter int FLOAT_LEN = 32,
    parameter int STAGE_W = 4
);
    logic start, loop, out_ready, out_valid, out_last, busy, done, cfg_err;
    logic [STAGE_W-1:0] stage;
    logic [2*FLOAT_LEN-1:0] out_data;
    modport master(input start, stage, loop, out_ready,
                   output out_valid, out_data, out_last, busy, done, cfg_err);
    modport slave(output start, stage, loop, out_ready,
                  input out_valid, out_data, out_last, busy, done, cfg_err);
endinterface

// File: rtl/tf_quarter_rom.sv
// tf_quarter_rom: quarter-wave {cos, -sin} table with a one-cycle registered read
module tf_quarter_rom #(
    parameter int FLOAT_LEN = 32,
    parameter int LOG2N = 13,
    parameter string ROM_INIT = "tf_quarter.mem"
) (
    input logic clk,
    input logic en,
    input logic [LOG2N-3:0] addr,
    output logic [2*FLOAT_LEN-1:0] dout
);
    localparam int DEPTH = 1 << (LOG2N - 2);
    localparam real PI = 3.14159265358979323846;
    logic [2*FLOAT_LEN-1:0] mem [DEPTH];
    function automatic logic [31:0] to_single(input real x);
        logic [63:0] d;
        logic [30:0] mag;
        logic up;
        d = $realtobits(x);
        up = d[28] && ((d[27:0] != '0) || d[29]);
        mag = {8'(d[62:52] - 11'd896), d[51:29]} + 31'(up);
        return (x == 0.0) ? {d[63], 31'd0} : {d[63], mag};
    endfunction
    function automatic logic [2*FLOAT_LEN-1:0] rom_word(input int r);
        real a;
        a = 2.0 * PI * $itor(r) / $itor(4 * DEPTH);
        return {to_single($cos(a)), to_single(-$sin(a))};
    endfunction
    for (genvar i = 0; i < DEPTH; i++) begin : g_e
        assign mem[i] = rom_word(i);
    end
    always_ff @(posedge clk) begin
        if (en) dout <= mem[addr];
    end
endmodule

// File: rtl/tf_provider_stream.sv
// tf_provider_stream: runtime-stage twiddle source for the radix-2 DIF FFT,
// quarter-wave ROM plus quadrant sign/swap behind a stallable 3-stage pipeline
module tf_provider_stream #(
    parameter int FLOAT_LEN = tf_pkg::FLOAT_LEN,
    parameter int LOG2N = tf_pkg::LOG2N,
    parameter int STAGE_W = 4,
    parameter string ROM_INIT = "tf_quarter.mem"
) (
    input logic clk,
    input logic rst,
    tf_provider_stream_if.master s
);
    import tf_pkg::state_t;
    import tf_pkg::IDLE;
    import tf_pkg::RUN;
    import tf_pkg::DRAIN;
    import tf_pkg::sign_flip;
    localparam int F = FLOAT_LEN;
    localparam int BW = LOG2N - 1;
    localparam int RW = LOG2N - 2;
    state_t state, nxt;
    logic [STAGE_W-1:0] stg, sh;
    logic [BW-1:0] b, j;
    logic [LOG2N-1:0] k;
    logic adv, issue, b_end, legal;
    logic [RW-1:0] r0;
    logic [1:0] q0, q1;
    logic l0, l1, v0, v1, ov, ol, dn, ce;
    logic [F-1:0] c, sn;
    logic [2*F-1:0] rom_q, tw, data;
    tf_quarter_rom #(.FLOAT_LEN(F), .LOG2N(LOG2N), .ROM_INIT(ROM_INIT)) rom (
        .clk(clk), .en(adv), .addr(r0), .dout(rom_q)
    );
    always_comb begin
        adv = !ov || s.out_ready;
        issue = (state == RUN) && adv;
        b_end = &b;
        legal = (s.stage != '0) && (s.stage <= STAGE_W'(LOG2N));
        sh = stg - STAGE_W'(1);
        j = b & ({BW{1'b1}} >> sh);
        k = {1'b0, j} << sh;
        c = rom_q[2*F-1:F];
        sn = rom_q[F-1:0];
        tw = (q1 == 2'd0) ? {c, sn} :
             (q1 == 2'd1) ? {sn, sign_flip(c)} :
             (q1 == 2'd2) ? {sign_flip(c), sign_flip(sn)} : {sign_flip(sn), c};
        nxt = (state == IDLE) ? ((s.start && legal) ? RUN : IDLE) :
              (state == RUN) ? ((issue && b_end && !s.loop) ? DRAIN : RUN) :
              ((!v0 && !v1 && !ov) ? IDLE : DRAIN);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg <= '0;
            b <= '0;
            r0 <= '0;
            q0 <= '0;
            q1 <= '0;
            {l0, l1, v0, v1, ov, ol, dn, ce} <= '0;
            data <= '0;
        end else begin
            if (state == IDLE && s.start && legal) begin
                stg <= s.stage;
                b <= '0;
            end else if (issue) b <= b + BW'(1);
            // every stage moves together so a stall freezes the whole pipe
            if (adv) begin
                v0 <= issue;
                r0 <= k[RW-1:0];
                q0 <= k[LOG2N-1:RW];
                l0 <= issue && b_end;
                v1 <= v0;
                q1 <= q0;
                l1 <= l0;
                ov <= v1;
                ol <= l1;
                data <= tw;
            end
            dn <= ov && s.out_ready && ol;
            ce <= (state == IDLE) && s.start && !legal;
        end
    end
    assign s.out_valid = ov;
    assign s.out_data = data;
    assign s.out_last = ol;
    assign s.busy = (state != IDLE);
    assign s.done = dn;
    assign s.cfg_err = ce;
endmodule

// File: tb/tb_tf_provider_stream.sv
// tb_tf_provider_stream: directed scenarios for the twiddle provider with an expected-beat queue
module tb_tf_provider_stream;
    localparam int F = 32;
    localparam int L = 4;
    localparam int SW = 4;
    typedef struct packed {
        logic [63:0] d;
        logic l;
    } beat_t;
    logic clk = 1'b0;
    logic rst;
    logic [63:0] tw [8];
    beat_t sb[$];
    int checks, errors, beats, dones, fc, lc;
    always #5 clk = ~clk;
    tf_provider_stream_if #(.FLOAT_LEN(F), .STAGE_W(SW)) s();
    tf_provider_stream #(.FLOAT_LEN(F), .LOG2N(L), .STAGE_W(SW), .ROM_INIT("")) dut (
        .clk(clk), .rst(rst), .s(s)
    );
    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic push_frame(input int st);
        int kk;
        for (int b = 0; b < 8; b++) begin
            kk = (b % ((1 << L) >> st)) << (st - 1);
            sb.push_back({tw[kk], b == 7});
        end
    endtask
    task automatic start_frame(input int st, input bit lp);
        s.stage = SW'(st);
        s.loop = lp;
        s.start = 1'b1;
        @(negedge clk);
        s.start = 1'b0;
    endtask
    task automatic drain(input bit rnd, input int drop_at);
        int cyc;
        bit held, pend;
        logic [65:0] hv;
        beat_t e;
        cyc = 0; held = 0; pend = 0; hv = '0;
        beats = 0; dones = 0; fc = -1; lc = -1;
        while ((sb.size() != 0 || s.busy) && cyc < 300) begin
            if (held) chk("hold", {s.out_valid, s.out_last, s.out_data}, hv);
            chk("done_timing", 66'(s.done), 66'(pend));
            if (s.done) dones++;
            pend = 0;
            if (s.out_valid && s.out_ready) begin
                if (sb.size() == 0) chk("extra_beat", 66'(1), 66'(0));
                else begin
                    e = sb.pop_front();
                    chk("beat", {1'b0, s.out_last, s.out_data}, {1'b0, e.l, e.d});
                end
                beats++;
                if (fc < 0) fc = cyc;
                lc = cyc;
                pend = s.out_last;
                if (beats == drop_at) s.loop = 1'b0;
            end
            held = s.out_valid && !s.out_ready;
            hv = {s.out_valid, s.out_last, s.out_data};
            @(negedge clk);
            s.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        chk("drain_timeout", 66'(cyc >= 300), 66'(0));
        s.out_ready = 1'b1;
    endtask
    initial begin
        int n;
        tw = '{64'h3F800000_80000000, 64'h3F6C835E_BEC3EF15, 64'h3F3504F3_BF3504F3,
               64'h3EC3EF15_BF6C835E, 64'h80000000_BF800000, 64'hBEC3EF15_BF6C835E,
               64'hBF3504F3_BF3504F3, 64'hBF6C835E_BEC3EF15};
        checks = 0; errors = 0;
        rst = 1'b1;
        s.start = 1'b0; s.stage = '0; s.loop = 1'b0; s.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {s.out_valid, s.out_last, s.out_data},
            66'(0));
        chk("rst_flags", 66'({s.busy, s.done, s.cfg_err}), 66'(0));
        rst = 1'b0;
        @(negedge clk);
        // stage 2: k = 0,2,4,6 twice, first beat three cycles after the first issue
        push_frame(2);
        start_frame(2, 0);
        chk("t1_busy", 66'(s.busy), 66'(1));
        repeat (2) begin
            @(negedge clk);
            chk("t1_latency_idle", 66'(s.out_valid), 66'(0));
        end
        @(negedge clk);
        chk("t1_latency_valid", 66'(s.out_valid), 66'(1));
        drain(0, 0);
        chk("t1_beats", 66'(beats), 66'(8));
        chk("t1_dones", 66'(dones), 66'(1));
        chk("t1_no_bubble", 66'(lc - fc), 66'(7));
        chk("t1_idle", 66'(s.busy), 66'(0));
        // stage 1: k = b
        push_frame(1);
        start_frame(1, 0);
        drain(0, 0);
        chk("t2_beats", 66'(beats), 66'(8));
        // stage = LOG2N: k = 0 every beat
        push_frame(4);
        start_frame(4, 0);
        drain(0, 0);
        chk("t3_beats", 66'(beats), 66'(8));
        chk("t3_dones", 66'(dones), 66'(1));
        // illegal stages
        start_frame(0, 0);
        chk("t4_cfg_err0", 66'({s.cfg_err, s.busy}), 66'(2'b10));
        @(negedge clk);
        chk("t4_cfg_clear0", 66'({s.cfg_err, s.busy, s.out_valid}), 66'(0));
        start_frame(5, 0);
        chk("t4_cfg_err5", 66'({s.cfg_err, s.busy}), 66'(2'b10));
        repeat (4) @(negedge clk);
        chk("t4_quiet5", 66'({s.cfg_err, s.busy, s.out_valid}), 66'(0));
        // stage 3 under random backpressure
        push_frame(3);
        start_frame(3, 0);
        drain(1, 0);
        chk("t5_beats", 66'(beats), 66'(8));
        chk("t5_dones", 66'(dones), 66'(1));
        // loop mode for two frames, dropped during the third
        push_frame(2); push_frame(2); push_frame(2);
        start_frame(2, 1);
        drain(0, 16);
        chk("t6_beats", 66'(beats), 66'(24));
        chk("t6_dones", 66'(dones), 66'(3));
        chk("t6_no_bubble", 66'(lc - fc), 66'(23));
        chk("t6_idle", 66'(s.busy), 66'(0));
        // reset on the 5th beat aborts without done
        start_frame(2, 0);
        n = 0;
        for (int c = 0; c < 50 && n < 5; c++) begin
            if (s.out_valid) n++;
            if (n < 5) @(negedge clk);
        end
        chk("t7_reached5", 66'(n), 66'(5));
        rst = 1'b1;
        #1;
        chk("t7_rst_out", {s.out_valid, s.out_last, s.out_data}, 66'(0));
        chk("t7_rst_flags", 66'({s.busy, s.done, s.cfg_err}), 66'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t7_no_done", 66'({s.done, s.out_valid, s.busy}), 66'(0));
        push_frame(2);
        start_frame(2, 0);
        drain(0, 0);
        chk("t7_fresh_beats", 66'(beats), 66'(8));
        chk("t7_fresh_dones", 66'(dones), 66'(1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
